dma_channel_arbiter: RTL
========================

Name: dma_channel_arbiter

Overview:
Parametrised N-channel request arbiter for the DMA controller. Generalises the 4-channel fixed/rotating encoder to NUM_CH channels and adds software requests, HRQ generation and EOP-terminated service. Sits between the I/O DREQ/DACK pins, the command/mask/request registers and the timing/control FSM. It owns the HRQ/HLDA bus handshake and supplies the granted channel ID to the address/count datapath.

Parameters:
NUM_CH, 8, number of DMA channels (2..16).
CH_W, $clog2(NUM_CH), width of the channel ID (derived; not overridden).

Ports:
Clock  input  1  system clock, all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Dreq  input  NUM_CH  raw hardware requests; polarity set by SenseDreq
SwReqSet  input  NUM_CH  one-cycle pulses from request-register writes; sets the software request bit
SwReqClr  input  NUM_CH  one-cycle pulses; clears the software request bit
Mask  input  NUM_CH  1 = hardware request ignored; software requests are not masked
RotatingPriority  input  1  0 = fixed priority (ch0 highest), 1 = rotating priority
SenseDreq  input  1  0 = DREQ active high, 1 = DREQ active low
SenseDack  input  1  0 = DACK active low, 1 = DACK active high
DMA_Disable  input  1  blocks new arbitration only
Hlda  input  1  hold acknowledge from the CPU
Eop  input  1  end of service for the granted channel (TC or external EOP), sampled in ACKNOWLEDGE
Hrq  output  1  hold request to the CPU, registered
Dack  output  NUM_CH  one-hot acknowledge, polarity set by SenseDack
ReqID  output  CH_W  granted channel, registered
ValidReqID  output  1  ReqID is meaningful
PendingReq  output  NUM_CH  registered valid-request image (status register)
SwReq  output  NUM_CH  software request bits (status readback)

Behaviour:
- Request sources:
  - ValidReq = ((Dreq ^ {NUM_CH{SenseDreq}}) & ~Mask) | SwReq.
  - PendingReq <= ValidReq every cycle.
- Software request bits:
  - A set pulse sets the bit; a clear pulse clears it.
  - Set and clear on the same bit in the same cycle: set wins.
  - The bit of ReqID is also cleared on Eop completion.
- Reset:
  - State = ARBITER, Hrq = 0, ReqID = 0, ValidReqID = 0, PendingReq = 0, SwReq = 0, leastPriority = NUM_CH-1.
  - Dack is driven to the inactive level.
  - Reset overrides any in-progress service; no Eop completion side effects occur.
- States: ARBITER, REQUEST, ACKNOWLEDGE, RELEASE.
- ARBITER:
  - Condition: |ValidReq & ~Hlda & ~DMA_Disable.
  - When true, at the next edge: latch ReqID, Hrq <= 1, go to REQUEST.
  - ValidReqID is asserted combinationally in the same cycle.
  - If Hlda is high (bus held by another master), wait.
- Selection:
  - Fixed: lowest-index valid channel.
  - Rotating: first valid channel scanning from leastPriority+1 upward, wrapping modulo NUM_CH; leastPriority itself is last.
- REQUEST:
  - Hrq = 1, ValidReqID = 1.
  - ReqID is frozen even if the request drops or DMA_Disable rises.
  - Hlda = 1 -> ACKNOWLEDGE.
- ACKNOWLEDGE:
  - Dack[ReqID] active, ValidReqID = 1, Hrq = 1.
  - Dack is combinational from state/ReqID, so it is active in the first ACKNOWLEDGE cycle (one cycle after Hlda is sampled).
  - Eop = 1 -> RELEASE. Clear SwReq[ReqID]. If RotatingPriority, leastPriority <= ReqID. Hrq <= 0.
  - Hlda drops without Eop (CPU pre-emption) -> ARBITER. Hrq <= 0; priority and SwReq unchanged; the channel re-competes.
  - Eop and an Hlda drop in the same cycle: treat as Eop.
- RELEASE:
  - Hrq = 0, Dack inactive, ValidReqID = 0.
  - Hlda = 0 -> ARBITER.
  - Minimum gap between services is therefore 2 cycles.
- Dack encoding: Dack = oneHot ~^ {NUM_CH{SenseDack}}; all bits are inactive outside ACKNOWLEDGE.
- Assertions:
  - Control inputs are never X after reset.
  - Dack is one-hot or zero after polarity correction.
  - Hrq is low in ARBITER and RELEASE.

Decomposition:
- Package dma_arb_pkg holds:
  - Arbiter state enum.
  - Function rot_select(valid, least), returning the chosen ID.
  - Function onehot(id).
- One sub-module, dma_rr_select: purely combinational fixed/rotating selector, parametrised by NUM_CH.
- The FSM and registers stay in dma_channel_arbiter.

Test Plan:
1. NUM_CH=8, fixed, Dreq=0x28, Mask=0. Expected: ReqID=3, Hrq next cycle. Hlda=1 -> Dack=0x08 (SenseDack=1). Eop -> Hrq=0; after Hlda=0, state ARBITER and ReqID=5 granted.
2. Rotating, Dreq=0xFF held, Eop after each service. Expected grant order 0,1,...,7,0 (wrap after leastPriority=7).
3. Mask=0x01, Dreq=0x01, SwReqSet=0x01. Expected: grant ch0 via software. SwReq clears to 0 on Eop; no further grant.
4. SenseDreq=1, Dreq=0xFD. Expected: ReqID=1. SenseDack=0 -> Dack=0xFD during ACKNOWLEDGE, 0xFF otherwise.
5. In ACKNOWLEDGE, Hlda drops without Eop. Expected: state ARBITER, leastPriority unchanged, same channel re-requested. DMA_Disable=1 in REQUEST: grant still completes, no new arbitration afterwards.
6. Reset asserted in ACKNOWLEDGE. Expected next cycle: Hrq=0, Dack inactive, SwReq=0, ValidReqID=0, leastPriority=7.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// ----------------------------------------------------------------------------
// dma_arb_pkg
//   Shared types and helpers for the DMA channel arbiter.
//   - arb_state_e : arbiter / bus-handshake FSM states
//   - rot_select  : rotating-priority scan over a request vector
//   - onehot      : channel ID to one-hot decode
//   Helpers work on a fixed MaxCh-wide vector; callers zero-extend their
//   NUM_CH-wide vectors and truncate the results back.
// ----------------------------------------------------------------------------
package dma_arb_pkg;

    localparam int unsigned MaxCh   = 16;
    localparam int unsigned MaxChW  = 4;
    localparam int unsigned MaxIdxW = MaxChW + 1;

    typedef enum logic [1:0] {
        StArbiter,
        StRequest,
        StAcknowledge,
        StRelease
    } arb_state_e;

    // First set bit of valid scanning upward from least+1, wrapping modulo
    // num_ch, with least itself examined last. Returns 0 when nothing is set.
    function automatic logic [MaxChW-1:0] rot_select(input logic [MaxCh-1:0]  valid,
                                                     input logic [MaxChW-1:0] least,
                                                     input int                num_ch);
        logic [MaxChW-1:0]  sel;
        logic               found;
        logic [MaxIdxW-1:0] idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= int'(MaxCh); i++) begin
            idx = {1'b0, least} + MaxIdxW'(i);
            // least < num_ch and i <= num_ch, so one subtraction wraps it
            if (idx >= MaxIdxW'(num_ch)) begin
                idx = idx - MaxIdxW'(num_ch);
            end
            if (!found && (i <= num_ch) && valid[idx[MaxChW-1:0]]) begin
                sel   = idx[MaxChW-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [MaxCh-1:0] onehot(input logic [MaxChW-1:0] id);
        logic [MaxCh-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dma_rr_select.sv
// ----------------------------------------------------------------------------
// dma_rr_select
//   Purely combinational channel selector, fixed or rotating priority.
//   Ports:
//     valid_i    : per-channel valid request vector
//     least_i    : last-served (lowest priority) channel for rotating mode
//     rotating_i : 0 = fixed (ch0 highest), 1 = rotating
//     sel_o      : selected channel ID (0 when nothing valid)
//     any_o      : at least one channel is requesting
// ----------------------------------------------------------------------------
module dma_rr_select
    import dma_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH = 8,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid_i,
    input  logic [CH_W-1:0]   least_i,
    input  logic              rotating_i,
    output logic [CH_W-1:0]   sel_o,
    output logic              any_o
);

    logic [CH_W-1:0] least_eff;

    always_comb begin
        // Fixed priority is the rotating scan with the top channel pinned as
        // the last-served one: the scan then starts at ch0.
        least_eff = rotating_i ? least_i : CH_W'(NUM_CH - 1);
        sel_o     = CH_W'(rot_select(MaxCh'(valid_i), MaxChW'(least_eff), int'(NUM_CH)));
        any_o     = |valid_i;
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// ----------------------------------------------------------------------------
// dma_channel_arbiter
//   NUM_CH-channel DMA request arbiter with HRQ/HLDA handshake, software
//   requests and EOP-terminated service.
//   Ports:
//     clock_i, reset_i      : clock, synchronous active-high reset
//     dreq_i                : raw hardware requests (polarity by sense_dreq_i)
//     sw_req_set_i/_clr_i   : one-cycle set/clear pulses for software requests
//     mask_i                : 1 = ignore hardware request of that channel
//     rotating_priority_i   : 0 = fixed, 1 = rotating priority
//     sense_dreq_i          : 0 = DREQ active high, 1 = active low
//     sense_dack_i          : 0 = DACK active low, 1 = active high
//     dma_disable_i         : blocks new arbitration only
//     hlda_i                : hold acknowledge from the CPU
//     eop_i                 : end of service for the granted channel
//     hrq_o                 : registered hold request
//     dack_o                : one-hot acknowledge, polarity by sense_dack_i
//     req_id_o              : registered granted channel
//     valid_req_id_o        : req_id_o is meaningful
//     pending_req_o         : registered valid-request image
//     sw_req_o              : software request bits
// ----------------------------------------------------------------------------
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH = 8,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] dreq_i,
    input  logic [NUM_CH-1:0] sw_req_set_i,
    input  logic [NUM_CH-1:0] sw_req_clr_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              rotating_priority_i,
    input  logic              sense_dreq_i,
    input  logic              sense_dack_i,
    input  logic              dma_disable_i,
    input  logic              hlda_i,
    input  logic              eop_i,
    output logic              hrq_o,
    output logic [NUM_CH-1:0] dack_o,
    output logic [CH_W-1:0]   req_id_o,
    output logic              valid_req_id_o,
    output logic [NUM_CH-1:0] pending_req_o,
    output logic [NUM_CH-1:0] sw_req_o
);

    arb_state_e        state_q;
    logic              hrq_q;
    logic [CH_W-1:0]   req_id_q;
    logic [CH_W-1:0]   least_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] sw_req_q;
    logic [NUM_CH-1:0] sw_req_d;

    logic [NUM_CH-1:0] valid_req;
    logic [CH_W-1:0]   sel_id;
    logic              any_req;
    logic              arb_go;
    logic              eop_done;
    logic [NUM_CH-1:0] dack_oh;

    dma_rr_select #(
        .NUM_CH(NUM_CH)
    ) u_select (
        .valid_i   (valid_req),
        .least_i   (least_q),
        .rotating_i(rotating_priority_i),
        .sel_o     (sel_id),
        .any_o     (any_req)
    );

    always_comb begin
        // Software requests bypass the mask.
        valid_req = ((dreq_i ^ {NUM_CH{sense_dreq_i}}) & ~mask_i) | sw_req_q;
        arb_go    = (state_q == StArbiter) && any_req && !hlda_i && !dma_disable_i;
        eop_done  = (state_q == StAcknowledge) && eop_i;

        sw_req_d = sw_req_q;
        if (eop_done) begin
            sw_req_d[req_id_q] = 1'b0;
        end
        // Set is applied last so it wins over any clear in the same cycle.
        sw_req_d = (sw_req_d & ~sw_req_clr_i) | sw_req_set_i;

        dack_oh = '0;
        if (state_q == StAcknowledge) begin
            dack_oh = NUM_CH'(onehot(MaxChW'(req_id_q)));
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StArbiter;
            hrq_q     <= 1'b0;
            req_id_q  <= '0;
            least_q   <= CH_W'(NUM_CH - 1);
            pending_q <= '0;
            sw_req_q  <= '0;
        end else begin
            pending_q <= valid_req;
            sw_req_q  <= sw_req_d;
            unique case (state_q)
                StArbiter: begin
                    if (arb_go) begin
                        req_id_q <= sel_id;
                        hrq_q    <= 1'b1;
                        state_q  <= StRequest;
                    end
                end
                StRequest: begin
                    // req_id_q stays frozen here regardless of requests or disable.
                    if (hlda_i) begin
                        state_q <= StAcknowledge;
                    end
                end
                StAcknowledge: begin
                    if (eop_i) begin
                        state_q <= StRelease;
                        hrq_q   <= 1'b0;
                        if (rotating_priority_i) begin
                            least_q <= req_id_q;
                        end
                    end else if (!hlda_i) begin
                        // CPU pre-empted the bus: re-compete, priority untouched.
                        state_q <= StArbiter;
                        hrq_q   <= 1'b0;
                    end
                end
                StRelease: begin
                    if (!hlda_i) begin
                        state_q <= StArbiter;
                    end
                end
                default: begin
                    state_q <= StArbiter;
                end
            endcase
        end
    end

    assign hrq_o          = hrq_q;
    assign req_id_o       = req_id_q;
    assign pending_req_o  = pending_q;
    assign sw_req_o       = sw_req_q;
    assign valid_req_id_o = arb_go || (state_q == StRequest) || (state_q == StAcknowledge);
    assign dack_o         = dack_oh ~^ {NUM_CH{sense_dack_i}};

    a_ctrl_known : assert property (@(posedge clock_i) disable iff (reset_i)
        !$isunknown({dreq_i, sw_req_set_i, sw_req_clr_i, mask_i, rotating_priority_i,
                     sense_dreq_i, sense_dack_i, dma_disable_i, hlda_i, eop_i}));

    a_dack_onehot : assert property (@(posedge clock_i) disable iff (reset_i)
        $onehot0(dack_o ~^ {NUM_CH{sense_dack_i}}));

    a_hrq_idle : assert property (@(posedge clock_i) disable iff (reset_i)
        ((state_q == StArbiter) || (state_q == StRelease)) |-> !hrq_q);

endmodule
